// File: rtl/llc_fifo_proc_update.sv
// Packet FIFO between the LLC process stage and the update stage.
// First-word-fall-through. An empty FIFO presents an all-zero packet.
// Overflow and underflow errors are sticky until err_clr.

package llc_fifo_proc_update_pkg;
   typedef struct packed {
      logic        is_req_to_get;
      logic        is_rsp_to_get;
      logic        is_rst_to_resume;
      logic        is_wb_ack;
      logic [15:0] addr;
      logic [31:0] data;
   } fifo_proc_update_packet;
endpackage

module llc_fifo_proc_update
   import llc_fifo_proc_update_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = DEPTH - 1,
   localparam int PW      = $clog2(DEPTH),
   localparam int CW      = PW + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fifo_push_update,
   input  fifo_proc_update_packet fifo_update_in,
   input  logic                   fifo_pop_update,
   output fifo_proc_update_packet fifo_update_out,
   output logic                   fifo_empty_update,
   output logic                   fifo_full_update,
   output logic                   fifo_almost_full_update,
   output logic [CW-1:0]          fifo_count_update,
   input  logic                   err_clr,
   output logic                   err_overflow,
   output logic                   err_underflow
);

   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] LP_AF    = CW'(AF_LEVEL);

   fifo_proc_update_packet r_mem [DEPTH];
   logic [PW-1:0]          r_head;
   logic [PW-1:0]          r_tail;
   logic [CW-1:0]          r_count;
   logic                   r_err_ovf;
   logic                   r_err_unf;

   logic w_empty;
   logic w_full;
   logic w_pop_ok;
   logic w_push_ok;
   logic w_ovf;
   logic w_unf;

   // Handshake qualification. All of it is based on the registered count.
   // A push into a full FIFO is still taken when a real pop frees the head
   // in the same cycle.
   always_comb begin
      w_empty   = (r_count == '0);
      w_full    = (r_count == LP_DEPTH);
      w_pop_ok  = fifo_pop_update && !w_empty;
      w_push_ok = fifo_push_update && (!w_full || w_pop_ok);
      w_ovf     = fifo_push_update && !w_push_ok;
      w_unf     = fifo_pop_update && w_empty;
   end

   // Entry storage. It has no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_tail] <= fifo_update_in;
   end

   // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) r_tail <= r_tail + PW'(1);
         if (w_pop_ok)  r_head <= r_head + PW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky error flags. A new error wins over a clear in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_ovf <= 1'b0;
         r_err_unf <= 1'b0;
      end else begin
         if (w_ovf)        r_err_ovf <= 1'b1;
         else if (err_clr) r_err_ovf <= 1'b0;
         if (w_unf)        r_err_unf <= 1'b1;
         else if (err_clr) r_err_unf <= 1'b0;
      end
   end

   // Outputs. The flags decode only the registered count. The head packet is
   // masked to zero when empty, so unqualified flag decoders stay idle.
   always_comb begin
      fifo_empty_update       = w_empty;
      fifo_full_update        = w_full;
      fifo_almost_full_update = (r_count >= LP_AF);
      fifo_count_update       = r_count;
      err_overflow            = r_err_ovf;
      err_underflow           = r_err_unf;
      fifo_update_out         = w_empty ? '0 : r_mem[r_head];
   end

endmodule

// File: tb/tb_llc_fifo_proc_update.sv
// Bench for llc_fifo_proc_update. It runs directed scenarios, then random traffic.
// A queue model supplies the expected flags, and a scoreboard checks head data.
module tb_llc_fifo_proc_update;
   import llc_fifo_proc_update_pkg::*;

   localparam int DEPTH = 4;
   localparam int AFL   = DEPTH - 1;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   fifo_push_update;
   fifo_proc_update_packet fifo_update_in;
   logic                   fifo_pop_update;
   fifo_proc_update_packet fifo_update_out;
   logic                   fifo_empty_update;
   logic                   fifo_full_update;
   logic                   fifo_almost_full_update;
   logic [2:0]             fifo_count_update;
   logic                   err_clr;
   logic                   err_overflow;
   logic                   err_underflow;

   llc_fifo_proc_update #(.DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .fifo_push_update        (fifo_push_update),
      .fifo_update_in          (fifo_update_in),
      .fifo_pop_update         (fifo_pop_update),
      .fifo_update_out         (fifo_update_out),
      .fifo_empty_update       (fifo_empty_update),
      .fifo_full_update        (fifo_full_update),
      .fifo_almost_full_update (fifo_almost_full_update),
      .fifo_count_update       (fifo_count_update),
      .err_clr                 (err_clr),
      .err_overflow            (err_overflow),
      .err_underflow           (err_underflow)
   );

   always #5 clk = ~clk;

   fifo_proc_update_packet m_q[$];
   fifo_proc_update_packet sb_q[$];
   bit m_ovf;
   bit m_unf;
   int n_checks = 0;
   int n_pass   = 0;

   function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endfunction

   function automatic void chk_pkt(string nm, fifo_proc_update_packet act,
                                   fifo_proc_update_packet exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endfunction

   function automatic fifo_proc_update_packet mk(logic [3:0] flags, logic [15:0] a,
                                                 logic [31:0] d);
      fifo_proc_update_packet p;
      p = {flags, a, d};
      return p;
   endfunction

   function automatic fifo_proc_update_packet rnd_pkt();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[51:0];
   endfunction

   // Scoreboard monitor. While the FIFO presents a head, it must equal the oldest
   // accepted packet, and a pop retires that packet. An empty FIFO presents zero.
   always @(negedge clk) begin
      if (rst) begin
         if (fifo_empty_update) begin
            chk_pkt("out_zero_when_empty", fifo_update_out, '0);
         end else if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL head_no_expected: got %h expected none at %0t", fifo_update_out, $time);
         end else begin
            chk_pkt("head_packet", fifo_update_out, sb_q[0]);
            if (fifo_pop_update) sb_q.delete(0);
         end
      end
   end

   function automatic void check_state();
      int n;
      n = m_q.size();
      chk("count",       8'(fifo_count_update),       8'(n));
      chk("empty",       8'(fifo_empty_update),       8'(n == 0));
      chk("full",        8'(fifo_full_update),        8'(n == DEPTH));
      chk("almost_full", 8'(fifo_almost_full_update), 8'(n >= AFL));
      chk("err_ovf",     8'(err_overflow),            8'(m_ovf));
      chk("err_unf",     8'(err_underflow),           8'(m_unf));
   endfunction

   // One clock of stimulus. The state before the edge is checked first, then
   // the model takes the effect of the coming edge.
   task automatic step(input bit push, input fifo_proc_update_packet pkt,
                       input bit pop, input bit clr);
      bit pop_ok, push_ok;
      @(posedge clk); #1;
      fifo_push_update = push;
      fifo_update_in   = pkt;
      fifo_pop_update  = pop;
      err_clr          = clr;
      @(negedge clk); #1;
      check_state();
      pop_ok  = pop && (m_q.size() > 0);
      push_ok = push && ((m_q.size() < DEPTH) || pop_ok);
      m_ovf   = (push && !push_ok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf   = (pop && m_q.size() == 0) ? 1'b1 : (clr ? 1'b0 : m_unf);
      if (pop_ok) m_q.delete(0);
      if (push_ok) begin
         m_q.push_back(pkt);
         sb_q.push_back(pkt);
      end
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic async_reset();
      @(posedge clk); #2;
      rst = 1'b0;
      fifo_push_update = 1'b0;
      fifo_pop_update  = 1'b0;
      err_clr          = 1'b0;
      #1;
      chk("rst_empty", 8'(fifo_empty_update), 8'd1);
      chk("rst_count", 8'(fifo_count_update), 8'd0);
      chk("rst_full",  8'(fifo_full_update),  8'd0);
      chk("rst_ovf",   8'(err_overflow),      8'd0);
      chk_pkt("rst_out", fifo_update_out, '0);
      m_q.delete();
      sb_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      fifo_proc_update_packet pa, pb, pc, pd;
      rst = 1'b0;
      fifo_push_update = 1'b0;
      fifo_pop_update  = 1'b0;
      fifo_update_in   = '0;
      err_clr          = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      #12;
      check_state();
      chk_pkt("reset_out", fifo_update_out, '0);
      @(posedge clk); #1 rst = 1'b1;

      // A then B, drained by two pops.
      pa = mk(4'b1000, 16'h00A0, 32'hAAAA_0001);
      pb = mk(4'b0100, 16'h00B0, 32'hBBBB_0002);
      step(1'b1, pa, 1'b0, 1'b0);
      step(1'b1, pb, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      idle();

      // Fill to full, then push once more to overflow.
      for (int i = 0; i < DEPTH + 1; i++) step(1'b1, mk(4'b0001, 16'(i), 32'(i + 100)), 1'b0, 1'b0);
      idle();

      // Push and pop together while full, enough times to wrap the pointers.
      for (int i = 0; i < 6; i++) step(1'b1, mk(4'b0010, 16'(i + 16), $urandom), 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
      idle();

      // Pop and push C together on an empty FIFO.
      pc = mk(4'b0010, 16'h00C0, 32'hCCCC_0003);
      step(1'b1, pc, 1'b1, 1'b0);
      idle();
      step(1'b0, '0, 1'b1, 1'b1);
      idle();

      // Reset asynchronously mid-cycle at count 3, then push D.
      for (int i = 0; i < 3; i++) step(1'b1, rnd_pkt(), 1'b0, 1'b0);
      async_reset();
      pd = mk(4'b1000, 16'h00D0, 32'hDDDD_0004);
      step(1'b1, pd, 1'b0, 1'b0);
      idle();
      step(1'b0, '0, 1'b1, 1'b0);

      // Clear alone, then clear together with an overflowing push.
      for (int i = 0; i < DEPTH + 1; i++) step(1'b1, rnd_pkt(), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, rnd_pkt(), 1'b0, 1'b1);
      idle();
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
      idle();

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) async_reset();
         else step($urandom_range(0, 99) < 55, rnd_pkt(),
                   $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 5);
      end
      idle();
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/llc_fifo_proc_update.md
LLC_FIFO_PROC_UPDATE -- requirements
Module: llc_fifo_proc_update

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of packet entries (power of two, 2..16).
REQ-002 SHALL have parameter AF_LEVEL, default 3 (DEPTH-1), meaning the occupancy at or above which fifo_almost_full_update asserts.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port fifo_push_update, input, 1, a push request from the process stage.
REQ-006 SHALL have port fifo_update_in, input, fifo_proc_update_packet, the packet to enqueue.
REQ-007 SHALL have port fifo_pop_update, input, 1, a pop request from the update stage.
REQ-008 SHALL have port fifo_update_out, output, fifo_proc_update_packet, the head packet.
REQ-009 SHALL have port fifo_empty_update, output, 1, asserted when occupancy is 0.
REQ-010 SHALL have port fifo_full_update, output, 1, asserted when occupancy equals DEPTH.
REQ-011 SHALL have port fifo_almost_full_update, output, 1, asserted when occupancy >= AF_LEVEL.
REQ-012 SHALL have port fifo_count_update, output, $clog2(DEPTH)+1, the current occupancy.
REQ-013 SHALL have port err_clr, input, 1, which clears the sticky error flags.
REQ-014 SHALL have port err_overflow, output, 1, a sticky flag for a push while full that is rejected.
REQ-015 SHALL have port err_underflow, output, 1, a sticky flag for a pop while empty.

Function
REQ-016 SHALL be first-word-fall-through: fifo_update_out SHALL be driven combinationally from the head entry whenever the FIFO is not empty.
REQ-017 SHALL drive fifo_update_out to an all-zero packet (every is_* flag 0) when empty, so a consumer that decodes the flags without qualification performs no write.
REQ-018 SHALL store fifo_update_in at the tail on a rising edge when fifo_push_update=1 and the push is accepted; the entry SHALL be visible on fifo_update_out the next cycle if the FIFO was empty (1-cycle latency, no same-cycle bypass).
REQ-019 SHALL advance the head on a rising edge when fifo_pop_update=1 and the FIFO is not empty.
REQ-020 SHALL accept a push when not full, or when full with a simultaneous valid pop.
REQ-021 SHALL, for a push when full without a pop, drop the packet, leave the FIFO state unchanged, and set err_overflow on the next edge.
REQ-022 SHALL, for a pop when empty, ignore the pop and set err_underflow; a simultaneous push in that cycle SHALL still be stored, so the count goes 0->1.
REQ-023 SHALL use the following count rules: push-only accepted +1, pop-only valid -1, both accepted 0, otherwise unchanged; the count SHALL never exceed DEPTH or go below 0.
REQ-024 SHALL use head/tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-025 SHALL register fifo_full_update, fifo_empty_update and fifo_almost_full_update, or derive them from the registered count only; no combinational path from push/pop to any flag.
REQ-026 SHALL clear err_overflow and err_underflow on the edge when err_clr=1; a new error in the same cycle SHALL take priority, so the flag remains 1.
REQ-027 SHALL leave entry contents unreset; only pointers, count and flags are reset.

Reset
REQ-028 SHALL, while rst=0 (asynchronously), force count=0, head=tail=0, fifo_empty_update=1, fifo_full_update=0, fifo_almost_full_update=0, err_overflow=0, err_underflow=0, and fifo_update_out=all-zero.
REQ-029 SHALL, on reset asserted mid-operation, discard all queued packets; after release the FIFO SHALL behave as freshly empty.

Verification
REQ-030 Push A(is_req_to_get=1), then B(is_rsp_to_get=1), then pop twice -> out=A one cycle after the first push, then B, then zero packet; count goes 1,2,1,0.
REQ-031 Push 4 packets with no pop -> full=1, almost_full=1 at count 3; a 5th push -> dropped, err_overflow=1, out is still the first packet.
REQ-032 At count 4, push plus pop in the same cycle -> count stays 4, the new packet lands at the tail, and the pointers wrap to 0 correctly.
REQ-033 When empty, pop plus push of C(is_rst_to_resume=1) -> err_underflow=1, count=1, out=C the next cycle.
REQ-034 Assert rst=0 at count 3, asynchronously (not on an edge) -> empty=1 immediately, out=0; after release, push D -> out=D, count=1.
REQ-035 With err_overflow=1, err_clr=1 alone -> flag cleared; err_clr=1 together with an overflowing push -> flag stays 1.
